// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
//   Loadable up/down modulo-MODULUS counter in the style of a cascadable
//   synchronous counter. It has a parallel enable (ENP), a trickle enable (ENT),
//   a combinational ripple-carry out (RCO) and a registered WRAP pulse.
//
// Parameters
//   WIDTH    counter width in bits, legal range 2..16
//   MODULUS  count modulus, legal range 2..2**WIDTH
//
// Ports
//   CLK   in   rising-edge clock
//   CLR   in   asynchronous active-high clear (Q = 0, WRAP = 0)
//   LD    in   synchronous load of PRE (clamped to MODULUS-1)
//   ENP   in   parallel count enable
//   ENT   in   trickle count enable, also gates RCO
//   UD    in   direction: 1 = up, 0 = down
//   PRE   in   preset value [WIDTH-1:0]
//   Q     out  registered count [WIDTH-1:0], always within 0..MODULUS-1
//   RCO   out  ENT & terminal-count, combinational (for cascading)
//   WRAP  out  one-cycle registered pulse after a counting wrap
//
// Edge priority: CLR, then LD, then count (ENP & ENT), otherwise hold.
// -----------------------------------------------------------------------------
module param_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             LD,
   input  logic             ENP,
   input  logic             ENT,
   input  logic             UD,
   input  logic [WIDTH-1:0] PRE,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             WRAP
);

   // Largest legal count. With MODULUS = 2**WIDTH this is all-ones, so the
   // explicit boundary handling below degenerates to plain binary wrap.
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   logic             at_top;
   logic             at_bot;
   logic             tc;
   logic             count_en;
   logic [WIDTH-1:0] pre_clamp;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;

   always_comb begin
      at_top    = (Q == MAX_Q);
      at_bot    = (Q == '0);
      // Terminal count depends on the direction currently requested, so RCO
      // follows UD with no clock edge.
      tc        = UD ? at_top : at_bot;
      count_en  = ENP & ENT;
      pre_clamp = (PRE > MAX_Q) ? MAX_Q : PRE;

      q_nxt     = Q;
      wrap_nxt  = 1'b0;

      if (LD) begin
         q_nxt = pre_clamp;
      end else if (count_en) begin
         // A counting edge taken at terminal count is exactly a wrap.
         wrap_nxt = tc;
         if (UD) begin
            q_nxt = at_top ? '0 : Q + WIDTH'(1);
         end else begin
            q_nxt = at_bot ? MAX_Q : Q - WIDTH'(1);
         end
      end
   end

   assign RCO = ENT & tc;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         Q    <= '0;
         WRAP <= 1'b0;
      end else begin
         Q    <= q_nxt;
         WRAP <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_param_counter.sv
// -----------------------------------------------------------------------------
// tb_param_counter
//   Directed and randomized checks of param_counter.
//   dut10       : WIDTH=4, MODULUS=10 (decade counter)
//   lo16 / hi16 : default parameters, cascaded through lo16.RCO -> hi16.ENT
// The expected values come from an arithmetic model of the counting rules
// (modulo arithmetic on plain integers).
// -----------------------------------------------------------------------------
module tb_param_counter;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // decade counter stimulus
   logic       d_clr, d_ld, d_enp, d_ent, d_ud;
   logic [3:0] d_pre;
   logic [3:0] d_q;
   logic       d_rco, d_wrap;

   // cascade stimulus (shared by both stages except ENT)
   logic       c_clr, c_ld, c_enp, c_ent, c_ud;
   logic [3:0] c_pre;
   logic [3:0] lo_q, hi_q;
   logic       lo_rco, lo_wrap, hi_rco, hi_wrap;

   param_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .CLK(clk), .CLR(d_clr), .LD(d_ld), .ENP(d_enp), .ENT(d_ent), .UD(d_ud),
      .PRE(d_pre), .Q(d_q), .RCO(d_rco), .WRAP(d_wrap)
   );

   param_counter lo16 (
      .CLK(clk), .CLR(c_clr), .LD(c_ld), .ENP(c_enp), .ENT(c_ent), .UD(c_ud),
      .PRE(c_pre), .Q(lo_q), .RCO(lo_rco), .WRAP(lo_wrap)
   );

   param_counter hi16 (
      .CLK(clk), .CLR(c_clr), .LD(c_ld), .ENP(c_enp), .ENT(lo_rco), .UD(c_ud),
      .PRE(c_pre), .Q(hi_q), .RCO(hi_rco), .WRAP(hi_wrap)
   );

   // ---------------------------------------------------------------- bookkeeping
   int checks = 0;
   int errors = 0;

   // model state
   int m_q;     // decade counter value
   bit m_w;     // decade counter WRAP
   int l_q;     // low cascade stage value
   bit l_w;     // low cascade stage WRAP

   // ---------------------------------------------------------------- reference model
   // Next value from the counting rules, using modulo arithmetic.
   function automatic int ref_next(int q, int m, bit ld, bit enp, bit ent,
                                   bit ud, int pre);
      if (ld)          return (pre > m - 1) ? m - 1 : pre;
      if (enp && ent)  return ud ? (q + 1) % m : (q - 1 + m) % m;
      return q;
   endfunction

   // A wrap is a counting step whose unreduced result leaves 0..m-1.
   function automatic bit ref_wrap(int q, int m, bit ld, bit enp, bit ent, bit ud);
      if (ld || !(enp && ent)) return 1'b0;
      return ud ? (q + 1 >= m) : (q - 1 < 0);
   endfunction

   function automatic bit ref_rco(int q, int m, bit ent, bit ud);
      return ent && (ud ? (q == m - 1) : (q == 0));
   endfunction

   // ---------------------------------------------------------------- scoreboard
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk10(input string tag);
      chk({tag, ".q"},    {28'd0, d_q}, m_q);
      chk({tag, ".wrap"}, {31'd0, d_wrap}, {31'd0, m_w});
      chk({tag, ".rco"},  {31'd0, d_rco},
          {31'd0, ref_rco(m_q, 10, d_ent, d_ud)});
   endtask

   // ---------------------------------------------------------------- drivers
   // One rising edge on the decade counter with the inputs currently applied.
   task automatic edge10(input string tag);
      int nq;
      bit nw;
      nq = ref_next(m_q, 10, d_ld, d_enp, d_ent, d_ud, int'(d_pre));
      nw = ref_wrap(m_q, 10, d_ld, d_enp, d_ent, d_ud);
      @(posedge clk);
      #1;
      m_q = nq;
      m_w = nw;
      chk10(tag);
   endtask

   // Mid-cycle asynchronous clear of the decade counter (called at edge+1).
   task automatic async_clr10(input string tag);
      #2 d_clr = 1'b1;
      #1;
      m_q = 0;
      m_w = 1'b0;
      chk10(tag);
      #1 d_clr = 1'b0;
   endtask

   task automatic edge16(input string tag);
      int nq;
      bit nw;
      nq = ref_next(l_q, 16, c_ld, c_enp, c_ent, c_ud, int'(c_pre));
      nw = ref_wrap(l_q, 16, c_ld, c_enp, c_ent, c_ud);
      @(posedge clk);
      #1;
      l_q = nq;
      l_w = nw;
      chk({tag, ".lo_q"},    {28'd0, lo_q}, l_q);
      chk({tag, ".lo_wrap"}, {31'd0, lo_wrap}, {31'd0, l_w});
   endtask

   // Bound on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- sequence
   initial begin
      d_clr = 1'b1; d_ld = 1'b0; d_enp = 1'b0; d_ent = 1'b0; d_ud = 1'b1; d_pre = '0;
      c_clr = 1'b1; c_ld = 1'b0; c_enp = 1'b0; c_ent = 1'b0; c_ud = 1'b1; c_pre = '0;
      m_q = 0; m_w = 1'b0; l_q = 0; l_w = 1'b0;

      // reset state before any clock edge
      #2;
      chk10("reset");
      chk("reset.lo_q", {28'd0, lo_q}, 0);
      chk("reset.hi_q", {28'd0, hi_q}, 0);
      #1 d_clr = 1'b0; c_clr = 1'b0;

      // decade up count: 12 edges, 0..9,0,1,2
      d_ud = 1'b1; d_enp = 1'b1; d_ent = 1'b1;
      for (int i = 0; i < 12; i++) edge10("decade_up");
      chk("decade_up.final", {28'd0, d_q}, 2);

      // load 3, count down 5 edges: 2,1,0,9,8
      d_ld = 1'b1; d_pre = 4'd3; d_ud = 1'b0;
      edge10("down_load");
      chk("down_load.value", {28'd0, d_q}, 3);
      d_ld = 1'b0;
      for (int i = 0; i < 5; i++) edge10("down_count");
      chk("down_count.final", {28'd0, d_q}, 8);

      // enables: load 5, ENP=0 holds, ENT=0 holds with RCO low
      d_ld = 1'b1; d_pre = 4'd5; d_ud = 1'b1;
      edge10("en_load");
      d_ld = 1'b0; d_enp = 1'b0; d_ent = 1'b1;
      for (int i = 0; i < 3; i++) edge10("hold_enp");
      d_enp = 1'b1; d_ent = 1'b0;
      edge10("hold_ent");
      chk("hold_ent.q", {28'd0, d_q}, 5);
      // clamp: PRE = 12 loads MODULUS-1, even with enables off
      d_ld = 1'b1; d_pre = 4'b1100; d_enp = 1'b0;
      edge10("clamp");
      chk("clamp.q", {28'd0, d_q}, 9);
      d_ld = 1'b0;

      // RCO follows ENT and UD immediately at Q = 9
      d_ent = 1'b1; d_ud = 1'b1; #1 chk10("rco_up");
      d_ud = 1'b0;               #1 chk10("rco_dn");
      d_ent = 1'b0; d_ud = 1'b1; #1 chk10("rco_ent_off");

      // async reset mid-count: load 0, count to 7, clear between edges
      d_ld = 1'b1; d_pre = 4'd0; d_enp = 1'b1; d_ent = 1'b1; d_ud = 1'b1;
      edge10("ar_load");
      d_ld = 1'b0;
      for (int i = 0; i < 7; i++) edge10("ar_count");
      chk("ar_count.q", {28'd0, d_q}, 7);
      async_clr10("ar_clear");
      // LD with CLR held has no effect
      d_clr = 1'b1; d_ld = 1'b1; d_pre = 4'd5;
      @(posedge clk);
      #1 chk10("ar_ld_ignored");
      d_clr = 1'b0; d_ld = 1'b0;

      // WRAP pulse cut short by an async clear
      d_ld = 1'b1; d_pre = 4'd9;
      edge10("aw_load");
      d_ld = 1'b0;
      edge10("aw_wrap");
      chk("aw_wrap.pulse", {31'd0, d_wrap}, 1);
      async_clr10("aw_clear");
      edge10("aw_after");   // first edge after CLR falls is normal

      // randomized traffic on the decade counter
      for (int i = 0; i < 300; i++) begin
         d_ld  = ($urandom_range(0, 7) == 0);
         d_enp = ($urandom_range(0, 3) != 0);
         d_ent = ($urandom_range(0, 3) != 0);
         d_ud  = $urandom_range(0, 1);
         d_pre = 4'($urandom_range(0, 15));
         edge10("rand");
         if ($urandom_range(0, 24) == 0) async_clr10("rand_clr");
      end
      d_ld = 1'b0;

      // default parameters: load 10, count up 6 edges -> 11..15,0
      c_ld = 1'b1; c_pre = 4'b1010; c_enp = 1'b1; c_ent = 1'b1; c_ud = 1'b1;
      edge16("def_load");
      c_ld = 1'b0;
      for (int i = 0; i < 6; i++) edge16("def_up");
      chk("def_up.final", {28'd0, lo_q}, 0);

      // cascade: clear, then 16 edges; high stage steps exactly once
      c_clr = 1'b1;
      #1;
      l_q = 0; l_w = 1'b0;
      chk("casc_clr.hi_q", {28'd0, hi_q}, 0);
      @(negedge clk) c_clr = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         edge16("casc");
         chk("casc.hi_q", {28'd0, hi_q}, i / 16);
      end
      c_enp = 1'b0;
      edge16("casc_hold");
      chk("casc_hold.hi_q", {28'd0, hi_q}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-002 Parameter MODULUS, default 16: count modulus; legal range 2..2^WIDTH.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 CLR  input  1  reset; asynchronous and active-high.
REQ-005 LD  input  1  synchronous load of PRE; active-high.
REQ-006 ENP  input  1  count enable (parallel); active-high.
REQ-007 ENT  input  1  count enable (trickle); active-high; also gates RCO.
REQ-008 UD  input  1  direction: 1 = count up, 0 = count down.
REQ-009 PRE  input  WIDTH  preset value.
REQ-010 Q  output  WIDTH  registered count value.
REQ-011 RCO  output  1  ripple carry out, combinational, for cascading.
REQ-012 WRAP  output  1  registered one-cycle pulse marking a completed wrap.

Function
REQ-013 Priority per rising edge, highest first: CLR, LD, count (ENP & ENT), hold.
REQ-014 LD loads PRE regardless of ENP, ENT and UD.
REQ-015 PRE > MODULUS-1 is clamped on load: Q <= MODULUS-1.
REQ-016 Count occurs only when ENP = 1, ENT = 1 and LD = 0.
REQ-017 Up (UD = 1): Q <= Q+1; at Q = MODULUS-1, Q <= 0.
REQ-018 Down (UD = 0): Q <= Q-1; at Q = 0, Q <= MODULUS-1.
REQ-019 Hold: ENP = 0 or ENT = 0 with LD = 0 keeps Q unchanged.
REQ-020 Terminal count TC = (UD & Q == MODULUS-1) | (~UD & Q == 0).
REQ-021 RCO = ENT & TC; it depends on ENT and UD without a clock edge, and is independent of ENP and LD.
REQ-022 WRAP = 1 for exactly the one cycle after an edge on which a counting transition wrapped (REQ-017/018 boundary case).
REQ-023 WRAP is 0 after a load, after a hold, and after a non-boundary count.
REQ-024 A UD change takes effect on the next edge; RCO follows UD immediately.
REQ-025 Q never takes a value outside 0..MODULUS-1.
REQ-026 When MODULUS = 2^WIDTH, wrap is natural binary overflow and underflow; behaviour is otherwise identical.
REQ-027 Latency: Q and WRAP update one clock after the qualifying edge; RCO has zero latency.

Reset
REQ-028 CLR = 1 forces Q = 0 and WRAP = 0 immediately, without waiting for CLK.
REQ-029 While CLR = 1, LD, ENP, ENT, UD and CLK are ignored; RCO = ENT & TC evaluated on Q = 0.
REQ-030 CLR asserted mid-count aborts the operation; no WRAP pulse is produced for the interrupted cycle.
REQ-031 After CLR falls, the first rising edge is evaluated normally per REQ-013.

Verification
REQ-032 Decade count, WIDTH=4, MODULUS=10: CLR pulse, UD=1, ENP=ENT=1 for 12 edges -> Q = 0..9,0,1,2; RCO=1 only while Q=9; WRAP=1 only in the cycle Q=0 following 9.
REQ-033 Down count with load, WIDTH=4, MODULUS=10: LD=1, PRE=3, UD=0, one edge -> Q=3; then count 5 edges -> Q = 2,1,0,9,8; RCO=1 only while Q=0 (ENT=1).
REQ-034 Enables and clamp, WIDTH=4, MODULUS=10: Q=5, ENP=0, ENT=1, 3 edges -> Q stays 5; ENP=1, ENT=0 -> Q stays 5 and RCO=0; LD=1 with PRE=4'b1100 -> Q=9.
REQ-035 Async reset, WIDTH=4, MODULUS=10: count to Q=7, assert CLR between edges -> Q=0 before the next edge; WRAP=0; LD=1 with CLR=1 has no effect.
REQ-036 Default parameters, WIDTH=4, MODULUS=16: PRE=4'b1010, LD pulse, count up 6 edges -> Q = 11..15,0 with WRAP pulse after 15->0. Cascade two instances (RCO of low stage to ENT of high stage), 16 edges -> high Q increments exactly once.
